max7000s_config_loader: RTL

Configuration sequencer for the EPM7032S behavioural model. It accepts a configuration image as a stream of bytes over a valid/ready handshake and assembles it MSB-first into a shadow register. It checks an 8-bit checksum, then updates the device's `bitstream` input in a single atomic step. It sits between the test/programming source and the `altera_max7000s` instance, which only ever sees a complete, checked image.

---
 rtl/max7000s_config_pkg.sv | 8 +
 rtl/config_shadow_register.sv | 20 ++
 rtl/max7000s_config_loader.sv | 76 +++++++
 3 files changed

// File: rtl/max7000s_config_pkg.sv
// max7000s_config_pkg: shared state encoding and sizing helpers for the configuration loader
package max7000s_config_pkg;
  localparam int checksum_width = 8;
  typedef enum logic [2:0] {IDLE, LOAD, SUM, DONE, ERROR} state_t;
  function automatic int calc_byte_count(input int bits);
    return (bits + 7) / 8;
  endfunction
endpackage

// File: rtl/config_shadow_register.sv
// config_shadow_register: MSB-first byte assembly into the shadow image, dropping bits past index 0
module config_shadow_register #(
  parameter int total_bit_count = 15033,
  parameter int idx_w = 11
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       write_enable,
  input  logic [idx_w-1:0]           byte_index,
  input  logic [7:0]                 data,
  output logic [total_bit_count-1:0] shadow
);
  always_ff @(posedge clock)
    if (reset || clear) shadow <= '0;
    else if (write_enable)
      for (int j = 0; j < total_bit_count; j++)
        if (byte_index == idx_w'((total_bit_count - 1 - j) / 8))
          shadow[j] <= data[3'(7 - (total_bit_count - 1 - j) % 8)];
endmodule

// File: rtl/max7000s_config_loader.sv
// max7000s_config_loader: streams a checksummed image into a shadow and commits it atomically to the device
module max7000s_config_loader
  import max7000s_config_pkg::*;
#(
  parameter int total_bit_count = 15033
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [7:0]                 data_in,
  input  logic                       data_valid,
  output logic                       data_ready,
  output logic [total_bit_count-1:0] bitstream,
  output logic                       configured,
  output logic                       busy,
  output logic                       error
);
  localparam int byte_count = calc_byte_count(total_bit_count);
  localparam int cnt_w = $clog2(byte_count + 1);
  state_t state;
  logic [cnt_w-1:0] count;
  logic [checksum_width-1:0] acc;
  logic [total_bit_count-1:0] shadow;
  logic xfer, last;
  assign data_ready = busy;
  assign xfer = data_valid && busy;
  assign last = count == cnt_w'(byte_count - 1);
  config_shadow_register #(.total_bit_count(total_bit_count), .idx_w(cnt_w)) u_shadow (
    .clock(clock),
    .reset(reset),
    .clear(start && !busy),
    .write_enable(xfer && state == LOAD),
    .byte_index(count),
    .data(data_in),
    .shadow(shadow)
  );
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      bitstream <= '1;
      configured <= 1'b0;
      busy <= 1'b0;
      error <= 1'b0;
      count <= '0;
      acc <= '0;
    end else
      case (state)
        LOAD:
          if (xfer) begin
            acc <= acc + data_in;
            count <= count + cnt_w'(1);
            if (last) state <= SUM;
          end
        SUM:
          if (xfer) begin
            busy <= 1'b0;
            // Only a matching checksum may touch the active image.
            if (data_in == acc) begin
              bitstream <= shadow;
              configured <= 1'b1;
              state <= DONE;
            end else begin
              error <= 1'b1;
              state <= ERROR;
            end
          end
        default:
          if (start) begin
            state <= LOAD;
            busy <= 1'b1;
            error <= 1'b0;
            count <= '0;
            acc <= '0;
          end
      endcase
endmodule
